// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch defaults and the fetch FSM states.
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Default byte increment per sequential fetch (16-bit instructions).
  localparam logic [INSTR_W-1:0] PC_STEP = 16'd2;

  // Default encoding that stops the fetch engine.
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched word and its address, with
// hold (neither control asserted) and flush (drop valid, keep payload).
module if_id_reg
  import cpu_pkg::INSTR_W;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [INSTR_W-1:0] i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_pc;
  logic               r_valid;

  // Register update: reset first, then flush, then load, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the RUN/HALT state, selects the
// next PC (redirect > stall > halt detect > sequential) and drives IF/ID.
module fetch_unit
  import cpu_pkg::INSTR_W;
  import cpu_pkg::fetch_state_t;
  import cpu_pkg::RUN;
  import cpu_pkg::HALT;
#(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter logic [15:0] PC_STEP   = cpu_pkg::PC_STEP,
  parameter logic [15:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_target,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] pcout,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  // The PC is kept even at every source so bit 0 always reads 0.
  localparam logic [INSTR_W-1:0] PC_RESET_EVEN = {PC_RESET[INSTR_W-1:1], 1'b0};

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] w_pc_next;
  logic [INSTR_W-1:0] w_pc_seq;
  logic [INSTR_W-1:0] w_pc_redirect;
  logic               r_halted;
  logic               w_ifid_load;
  logic               w_ifid_flush;

  assign w_pc_seq      = r_pc + PC_STEP;
  assign w_pc_redirect = {redirect_target[INSTR_W-1:1], 1'b0};

  // State, PC and halted flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_pc     <= PC_RESET_EVEN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_halted <= (w_state_next == HALT);
    end
  end

  // Next-state, next-PC and IF/ID controls in priority order.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect) begin
          w_pc_next    = w_pc_redirect;
          w_ifid_flush = 1'b1;
        end else if (stall) begin
          // Decode back-pressure: everything holds.
        end else if (instruction == HALT_WORD) begin
          w_state_next = HALT;
          w_ifid_flush = 1'b1;
        end else begin
          w_pc_next   = {w_pc_seq[INSTR_W-1:1], 1'b0};
          w_ifid_load = 1'b1;
        end
      end
      HALT: begin
        // Only reset leaves HALT; redirect and stall are ignored.
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_instr (instruction),
    .i_pc    (r_pc),
    .o_instr (if_id_instr),
    .o_pc    (if_id_pc),
    .o_valid (if_id_valid)
  );

  assign pcout  = r_pc;
  assign halted = r_halted;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'h0000: PC value loaded by reset.
REQ-002 SHALL have parameter PC_STEP, default 2: byte increment per sequential fetch.
REQ-003 SHALL have parameter HALT_WORD, default 16'h0000: instruction encoding that stops fetch.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  in  1  hold PC and IF/ID register (decode back-pressure).
REQ-007 SHALL have port redirect  in  1  taken branch/jump from execute.
REQ-008 SHALL have port redirect_target  in  16  new fetch address.
REQ-009 SHALL have port instruction  in  16  word returned combinationally by instruction memory for pcout.
REQ-010 SHALL have port pcout  out  16  current fetch address to instruction memory.
REQ-011 SHALL have port if_id_instr  out  16  registered fetched instruction.
REQ-012 SHALL have port if_id_pc  out  16  address the if_id_instr was fetched from.
REQ-013 SHALL have port if_id_valid  out  1  IF/ID holds a real instruction.
REQ-014 SHALL have port halted  out  1  fetch stopped on HALT_WORD.

Function
REQ-015 SHALL implement states RUN and HALT; reset enters RUN.
REQ-016 In RUN, per edge, SHALL apply priority redirect > stall > halt detect > sequential.
REQ-017 Sequential: pcout <= pcout + PC_STEP (16-bit modulo, 16'hFFFE wraps to 16'h0000); if_id_instr <= instruction; if_id_pc <= pcout; if_id_valid <= 1.
REQ-018 Latency: instruction presented at pcout in cycle N SHALL appear on if_id_instr after edge N+1.
REQ-019 Redirect: pcout <= {redirect_target[15:1],1'b0}; if_id_valid <= 0 (flush wrong-path word); if_id_instr/if_id_pc unchanged.
REQ-020 Redirect SHALL override simultaneous stall and simultaneous HALT_WORD fetch.
REQ-021 Stall (no redirect): pcout, if_id_instr, if_id_pc, if_id_valid all hold.
REQ-022 Halt detect (no redirect, no stall, instruction == HALT_WORD): state <= HALT; pcout holds at halt address; if_id_valid <= 0; halt word is not forwarded.
REQ-023 In HALT: pcout, if_id_* hold, if_id_valid stays 0, halted = 1; redirect and stall ignored; only reset exits.
REQ-024 halted SHALL be a registered output equal to (state == HALT).
REQ-025 pcout SHALL always be even; bit 0 reads 0.

Reset
REQ-026 On reset high at an edge: state <= RUN, pcout <= PC_RESET, if_id_instr <= 16'h0000, if_id_pc <= 16'h0000, if_id_valid <= 0, halted <= 0.
REQ-027 Reset SHALL take priority over every other input, including mid-stall, mid-redirect, and HALT.

Structure
REQ-028 Shared cpu package SHALL hold PC_STEP, HALT_WORD, instruction width (16), and the fetch state enum {RUN, HALT}.
REQ-029 IF/ID register (instr, pc, valid with hold/flush controls) SHALL be a sub-module named if_id_reg; next-PC selection stays in fetch_unit.

Verification
REQ-030 Reset release, memory returns F120 @0, F121 @2 -> edge 1: if_id_instr=F120, if_id_pc=0000, valid=1, pcout=0002; edge 2: if_id_instr=F121, if_id_pc=0002.
REQ-031 At pcout=0008, stall=1 for 3 cycles -> pcout=0008 and IF/ID frozen for 3 edges; sequential resume on release.
REQ-032 At pcout=001A, redirect=1, target=0023, stall=1 -> pcout=0022, if_id_valid=0 next edge; then if_id_instr = word @0022.
REQ-033 Word at 0036 = 0000 -> pcout stays 0036, halted=1, valid=0; redirect to 0000 ignored; reset -> pcout=0000, halted=0.
REQ-034 PC_RESET=16'hFFFE -> after one sequential edge pcout=0000, if_id_pc=FFFE.
REQ-035 Reset asserted during 2-cycle stall with valid=1 -> next edge all outputs at reset values.
